// File: rtl/pc_pkg.sv
// Shared definitions for the multi-thread PC sequencer: command priority
// encoding, the priority decoder and a width helper.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_CMD_RESET = 3'd0,
        PC_CMD_STOP  = 3'd1,
        PC_CMD_RET   = 3'd2,
        PC_CMD_CALL  = 3'd3,
        PC_CMD_JMP   = 3'd4,
        PC_CMD_INC   = 3'd5
    } pc_cmd_e;

    // Bits needed to encode 0..value-1; never below 1 so ports stay legal.
    function automatic int pc_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << result) < value) begin
                result = result + 1;
            end else begin
                result = result;
            end
        end
        if (result == 0) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

    function automatic pc_cmd_e pc_decode(input logic thread_reset, input logic stop,
                                          input logic ret, input logic call,
                                          input logic jmp);
        pc_cmd_e cmd;
        if (thread_reset) begin
            cmd = PC_CMD_RESET;
        end else if (stop) begin
            cmd = PC_CMD_STOP;
        end else if (ret) begin
            cmd = PC_CMD_RET;
        end else if (call) begin
            cmd = PC_CMD_CALL;
        end else if (jmp) begin
            cmd = PC_CMD_JMP;
        end else begin
            cmd = PC_CMD_INC;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/pc_call_stack.sv
// One return-address LIFO. Push is ignored when full, pop when empty;
// the owner detects those cases from full/empty and flags them.
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int Width     = 6,
    parameter int Depth     = 4,
    parameter int DepthBits = pc_clog2(Depth + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [Width-1:0]     push_data,
    output logic                 full,
    output logic                 empty,
    output logic [Width-1:0]     top,
    output logic [DepthBits-1:0] depth
);

    localparam int AddrBits = pc_clog2(Depth);

    logic [Width-1:0]     mem_q [Depth];
    logic [Width-1:0]     mem_d [Depth];
    logic [DepthBits-1:0] ptr_q;
    logic [DepthBits-1:0] ptr_d;
    logic [AddrBits-1:0]  wr_idx_s;
    logic [AddrBits-1:0]  rd_idx_s;

    assign full     = (ptr_q == DepthBits'(Depth));
    assign empty    = (ptr_q == '0);
    assign depth    = ptr_q;
    assign wr_idx_s = AddrBits'(ptr_q);
    assign rd_idx_s = AddrBits'(ptr_q - DepthBits'(1));
    assign top      = mem_q[rd_idx_s];

    // Next pointer and storage; clear wins over push/pop.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (push && !full) begin
            mem_d[wr_idx_s] = push_data;
            ptr_d           = ptr_q + DepthBits'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - DepthBits'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Stack state; hard reset wipes contents as well as the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-thread program counter: one selected thread is updated per cycle
// according to the prioritised command; the others hold.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int CounterBits = 6,
    parameter int Threads     = 4,
    parameter int StackDepth  = 4,
    parameter int ResetAddr   = 0,
    parameter int SelBits     = pc_clog2(Threads),
    parameter int DepthBits   = pc_clog2(StackDepth + 1)
) (
    input  logic                   CLK,
    input  logic                   CPU_SetResetN,
    input  logic [SelBits-1:0]     PC_ThreadSel,
    input  logic [CounterBits-1:0] PC_JMPAddr,
    input  logic                   PC_SetJmp,
    input  logic                   PC_SetCall,
    input  logic                   PC_SetRet,
    input  logic                   PC_SetStop,
    input  logic                   PC_ThreadReset,
    output logic [CounterBits-1:0] PC_Counter,
    output logic [Threads-1:0]     PC_StackErr,
    output logic [DepthBits-1:0]   PC_StackDepth
);

    localparam logic [CounterBits-1:0] RstPc = CounterBits'(ResetAddr);

    pc_cmd_e                cmd_s;
    logic [CounterBits-1:0] pc_q [Threads];
    logic [CounterBits-1:0] pc_d [Threads];
    logic [Threads-1:0]     err_q;
    logic [Threads-1:0]     err_d;
    logic [Threads-1:0]     push_s;
    logic [Threads-1:0]     pop_s;
    logic [Threads-1:0]     clr_s;
    logic [Threads-1:0]     full_s;
    logic [Threads-1:0]     empty_s;
    logic [CounterBits-1:0] top_s   [Threads];
    logic [CounterBits-1:0] ret_pc_s [Threads];
    logic [DepthBits-1:0]   depth_s [Threads];

    assign cmd_s = pc_decode(PC_ThreadReset, PC_SetStop, PC_SetRet, PC_SetCall, PC_SetJmp);

    for (genvar g = 0; g < Threads; g++) begin : g_stack
        assign ret_pc_s[g] = pc_q[g] + CounterBits'(1);

        pc_call_stack #(
            .Width     (CounterBits),
            .Depth     (StackDepth),
            .DepthBits (DepthBits)
        ) u_stack (
            .clk       (CLK),
            .rst_n     (CPU_SetResetN),
            .clear     (clr_s[g]),
            .push      (push_s[g]),
            .pop       (pop_s[g]),
            .push_data (ret_pc_s[g]),
            .full      (full_s[g]),
            .empty     (empty_s[g]),
            .top       (top_s[g]),
            .depth     (depth_s[g])
        );
    end

    // Per-thread next state; only the selected thread acts on the command.
    always_comb begin
        err_d  = err_q;
        push_s = '0;
        pop_s  = '0;
        clr_s  = '0;
        for (int t = 0; t < Threads; t++) begin
            pc_d[t] = pc_q[t];
            if (PC_ThreadSel == SelBits'(t)) begin
                case (cmd_s)
                    PC_CMD_RESET: begin
                        pc_d[t]  = RstPc;
                        err_d[t] = 1'b0;
                        clr_s[t] = 1'b1;
                    end
                    PC_CMD_STOP: pc_d[t] = pc_q[t];
                    PC_CMD_RET: begin
                        if (!empty_s[t]) begin
                            pc_d[t]  = top_s[t];
                            pop_s[t] = 1'b1;
                        end else begin
                            err_d[t] = 1'b1;
                        end
                    end
                    PC_CMD_CALL: begin
                        if (!full_s[t]) begin
                            pc_d[t]   = PC_JMPAddr;
                            push_s[t] = 1'b1;
                        end else begin
                            err_d[t] = 1'b1;
                        end
                    end
                    PC_CMD_JMP: pc_d[t] = PC_JMPAddr;
                    PC_CMD_INC: pc_d[t] = pc_q[t] + CounterBits'(1);
                    default:    pc_d[t] = pc_q[t];
                endcase
            end else begin
                pc_d[t] = pc_q[t];
            end
        end
    end

    // PC registers and sticky fault flags.
    always_ff @(posedge CLK or negedge CPU_SetResetN) begin
        if (!CPU_SetResetN) begin
            err_q <= '0;
            for (int t = 0; t < Threads; t++) begin
                pc_q[t] <= RstPc;
            end
        end else begin
            err_q <= err_d;
            pc_q  <= pc_d;
        end
    end

    // Read-out of the currently addressed thread.
    always_comb begin
        PC_Counter    = RstPc;
        PC_StackDepth = '0;
        if (int'(PC_ThreadSel) < Threads) begin
            PC_Counter    = pc_q[PC_ThreadSel];
            PC_StackDepth = depth_s[PC_ThreadSel];
        end else begin
            PC_Counter    = RstPc;
            PC_StackDepth = '0;
        end
    end

    assign PC_StackErr = err_q;

endmodule
